// File: rtl/counter_sched_rr_pkg.sv
// counter_sched_pkg: shared types and helpers for the round-robin counter
// scheduler.
//   sched_state_t   - scheduler FSM encoding (IDLE, COUNT, DONE)
//   DEFAULT_N_REQ   - default number of requesters
//   DEFAULT_CNT_W   - default shared counter width
//   MAX_REQ         - largest supported requester count
//   onehot()        - index to one-hot vector (MAX_REQ bits wide)
package counter_sched_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_CNT_W = 4;
    localparam int MAX_REQ       = 8;
    localparam int MAX_IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req       - request vector to arbitrate among
//   last      - index of the most recently granted requester
//   en        - arbitration enable; outputs are all zero when low
//   win       - one-hot winner
//   win_idx   - winner index
//   any_valid - a winner exists this cycle
// The search starts at last+1 and wraps, so the previous winner has the
// lowest priority. The pointer register lives in the parent.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IDX_W = $clog2(DEFAULT_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic             en,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_valid
);

    logic [IDX_W-1:0]   cand;
    logic [MAX_REQ-1:0] win_full;

    // Walk from the farthest candidate to the nearest; the nearest set bit
    // is assigned last and therefore wins.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (en && req[cand]) begin
                any_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_full = onehot(MAX_IDX_W'(win_idx));
        win      = any_valid ? win_full[N_REQ-1:0] : '0;
    end

endmodule

// File: rtl/counter_sched_rr.sv
// counter_sched_rr: round-robin scheduler sharing one up-counter among
// N_REQ requesters. A granted requester gets a window in which the counter
// runs 0..term (term latched from its req_term slice at grant), followed by
// a one-cycle done pulse.
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   req        - per-requester request level
//   req_term   - per-requester terminal count, slice i = [i*CNT_W +: CNT_W]
//   gnt        - one-hot grant, zero when no window is active
//   done       - one-hot, one-cycle pulse at window completion
//   count      - shared counter value
//   busy       - high in COUNT and DONE
// Optional build macro COUNTER_SCHED_BACK2BACK_EN: arbitrate in DONE and
// start the next window directly, with no idle cycle between windows.
//
// Request protocol: a requester raises req and holds it high; gnt[i] rises
// one cycle after req[i] is sampled high in IDLE. The window finishes with
// done[i] for exactly one cycle while gnt[i] is still high. Dropping req[i]
// while granted (before done) abandons the window: gnt falls on the next
// edge and no done is produced. The requester should drop req the cycle
// after done; if it keeps req high it simply requests again at lowest
// priority.
module counter_sched_rr
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_term,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [CNT_W-1:0]       count,
    output logic                   busy
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_COUNT = COUNT;
    localparam logic [1:0] S_DONE  = DONE;

    // state is the FSM debug view for checkers (encoding of sched_state_t).
    logic [1:0]       state;
    logic [N_REQ-1:0] gnt_r;
    logic [N_REQ-1:0] done_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] term_r;
    logic [IDX_W-1:0] last_r;

    logic             arb_en;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             any_valid;
    logic [CNT_W-1:0] term_sel;

    always_comb begin
        arb_en  = (state == S_IDLE);
        arb_req = req;
`ifdef COUNTER_SCHED_BACK2BACK_EN
        // The requester finishing now must not win again immediately.
        if (state == S_DONE) begin
            arb_en  = 1'b1;
            arb_req = req & ~gnt_r;
        end
`endif
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (arb_req),
        .last      (last_r),
        .en        (arb_en),
        .win       (win_oh),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        term_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) term_sel = req_term[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gnt_r   <= '0;
            done_r  <= '0;
            count_r <= '0;
            term_r  <= '0;
            last_r  <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        gnt_r   <= win_oh;
                        term_r  <= term_sel;
                        count_r <= '0;
                        last_r  <= win_idx;
                        state   <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    // last_r holds the index of the current grantee.
                    if (!req[last_r]) begin
                        gnt_r   <= '0;
                        count_r <= '0;
                        state   <= S_IDLE;
                    end else if (count_r == term_r) begin
                        done_r <= gnt_r;
                        state  <= S_DONE;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_r <= '0;
`ifdef COUNTER_SCHED_BACK2BACK_EN
                    if (any_valid) begin
                        gnt_r   <= win_oh;
                        term_r  <= term_sel;
                        count_r <= '0;
                        last_r  <= win_idx;
                        state   <= S_COUNT;
                    end else begin
                        gnt_r   <= '0;
                        count_r <= '0;
                        state   <= S_IDLE;
                    end
`else
                    gnt_r   <= '0;
                    count_r <= '0;
                    state   <= S_IDLE;
`endif
                end
                default: begin
                    gnt_r   <= '0;
                    done_r  <= '0;
                    count_r <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign done  = done_r;
    assign count = count_r;
    assign busy  = (state == S_COUNT) || (state == S_DONE);

endmodule

// File: tb/tb_counter_sched_rr.sv
// Directed bench for counter_sched_rr (N_REQ=4, CNT_W=4). Each step compares
// the packed observation {gnt, done, count, busy} against a hand-computed
// expectation.
module tb_counter_sched_rr;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_term;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   count;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic [12:0] exp_v;
    logic [12:0] obs;
    assign obs = {gnt, done, count, busy};

    always #5 clk = ~clk;

    counter_sched_rr #(.N_REQ(N), .CNT_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_term (req_term),
        .gnt      (gnt),
        .done     (done),
        .count    (count),
        .busy     (busy)
    );

    function automatic logic [N-1:0] oh(input int k);
        oh = 4'b0001 << k;
    endfunction

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_term = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_term = '0;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp_v); end
        rst_n = 1'b1;
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        req_term[0 +: W] = 4'd5;
        req = 4'b0001;
        for (int c = 0; c <= 3; c++) begin
            tick();
            exp_v = {oh(0), 4'b0, 4'(c), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rmid_count%0d got=%h want=%h", c, obs, exp_v); end
        end
        #2 rst_n = 1'b0;
        #1;
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rmid_async got=%h want=%h", obs, exp_v); end
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rmid_held got=%h want=%h", obs, exp_v); end
        rst_n = 1'b1;
        tick();
        exp_v = {oh(0), 4'b0, 4'd0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rmid_regrant got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_single();
        do_reset();
        req_term[2*W +: W] = 4'd3;
        req = 4'b0100;
        for (int c = 0; c <= 3; c++) begin
            tick();
            // Terminal changes after grant must not affect this window.
            if (c == 0) req_term[2*W +: W] = 4'd7;
            exp_v = {oh(2), 4'b0, 4'(c), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL single_count%0d got=%h want=%h", c, obs, exp_v); end
        end
        tick();
        exp_v = {oh(2), oh(2), 4'd3, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_done got=%h want=%h", obs, exp_v); end
        req = '0;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_after got=%h want=%h", obs, exp_v); end
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_quiet got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_rotation();
        int order [5];
        int terms [4];
        order = '{0, 1, 2, 3, 0};
        terms = '{1, 0, 2, 1};
        do_reset();
        for (int i = 0; i < N; i++) req_term[i*W +: W] = 4'(terms[i]);
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            for (int c = 0; c <= terms[order[w]]; c++) begin
                tick();
                exp_v = {oh(order[w]), 4'b0, 4'(c), 1'b1};
                total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rot_w%0d_c%0d got=%h want=%h", w, c, obs, exp_v); end
            end
            tick();
            exp_v = {oh(order[w]), oh(order[w]), 4'(terms[order[w]]), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rot_done%0d got=%h want=%h", w, obs, exp_v); end
`ifndef COUNTER_SCHED_BACK2BACK_EN
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rot_idle%0d got=%h want=%h", w, obs, exp_v); end
`endif
        end
        req = '0;
    endtask

    task automatic test_abort();
        do_reset();
        req_term[1*W +: W] = 4'd9;
        req_term[3*W +: W] = 4'd2;
        req = 4'b1010;
        for (int c = 0; c <= 4; c++) begin
            tick();
            exp_v = {oh(1), 4'b0, 4'(c), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL abort_count%0d got=%h want=%h", c, obs, exp_v); end
        end
        req = 4'b1000;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_drop got=%h want=%h", obs, exp_v); end
        tick();
        exp_v = {oh(3), 4'b0, 4'd0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_next got=%h want=%h", obs, exp_v); end
        req = '0;
    endtask

    task automatic test_edge_terms();
        do_reset();
        req_term[0 +: W] = 4'd0;
        req = 4'b0001;
        tick();
        exp_v = {oh(0), 4'b0, 4'd0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL t0_grant got=%h want=%h", obs, exp_v); end
        tick();
        exp_v = {oh(0), oh(0), 4'd0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL t0_done got=%h want=%h", obs, exp_v); end

        do_reset();
        req_term[2*W +: W] = 4'd15;
        req = 4'b0100;
        for (int c = 0; c <= 15; c++) begin
            tick();
            exp_v = {oh(2), 4'b0, 4'(c), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL t15_count%0d got=%h want=%h", c, obs, exp_v); end
        end
        tick();
        exp_v = {oh(2), oh(2), 4'd15, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL t15_done got=%h want=%h", obs, exp_v); end
        req = '0;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL t15_after got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_term[0 +: W] = 4'd1;
        req_term[1*W +: W] = 4'd1;
        req = 4'b0011;
        for (int c = 0; c <= 1; c++) begin
            tick();
            exp_v = {oh(0), 4'b0, 4'(c), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL b2b_w0_c%0d got=%h want=%h", c, obs, exp_v); end
        end
        tick();
        exp_v = {oh(0), oh(0), 4'd1, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_done0 got=%h want=%h", obs, exp_v); end
        req = 4'b0010;
`ifndef COUNTER_SCHED_BACK2BACK_EN
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_gap got=%h want=%h", obs, exp_v); end
`endif
        for (int c = 0; c <= 1; c++) begin
            tick();
            exp_v = {oh(1), 4'b0, 4'(c), 1'b1};
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL b2b_w1_c%0d got=%h want=%h", c, obs, exp_v); end
        end
        tick();
        exp_v = {oh(1), oh(1), 4'd1, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_done1 got=%h want=%h", obs, exp_v); end
        req = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_term = '0;
        test_reset();
        test_reset_mid_window();
        test_single();
        test_rotation();
        test_abort();
        test_edge_terms();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
